// File: rtl/uplink_frame_buffer.sv
// uplink_frame_buffer
//   Validates each burst from the uplink deserialiser, which is two sync words
//   followed by the payload. Payload words go into a two-bank ping-pong RAM.
//   Completed frames are handed to the RAM reader with a ready/ack handshake.
//   Frames that are malformed, too short or arrive while both banks are full
//   are dropped and counted.
//
// Ports
//   UpSig_RClk    recovered deserialiser clock (only clock)
//   nRst          asynchronous reset, active low
//   sync_success  link-sync flag; low abandons any frame and holds the FSM idle
//   UlDataIn      10-bit word from the upstream stage
//   UlDataInEn    word valid, one contiguous burst per frame
//   RamWrEn       RAM write strobe
//   RamWrAddr     {bank, word index}
//   RamWrData     payload word
//   FrameRdy      oldest bank holds a complete frame
//   FrameBank     bank the reader should read
//   FrameLen      payload length stored for FrameBank
//   FrameAck      1-cycle pulse, reader is done with FrameBank
//   DropCnt       dropped-frame counter, saturates at 255
module uplink_frame_buffer #(
  parameter int          PAYLOAD_MAX = 260,
  parameter int          PAYLOAD_MIN = 38,
  parameter logic [9:0]  SYNC_A      = 10'h287,
  parameter logic [9:0]  SYNC_B      = 10'h2B8,
  parameter int          AW          = 9
) (
  input  logic          UpSig_RClk,
  input  logic          nRst,
  input  logic          sync_success,
  input  logic [9:0]    UlDataIn,
  input  logic          UlDataInEn,
  output logic          RamWrEn,
  output logic [AW:0]   RamWrAddr,
  output logic [9:0]    RamWrData,
  output logic          FrameRdy,
  output logic          FrameBank,
  output logic [AW-1:0] FrameLen,
  input  logic          FrameAck,
  output logic [7:0]    DropCnt
);

  typedef enum logic [1:0] {IDLE, SYNC2, PAYLOAD, DROP} state_t;

  state_t               state, state_nxt;
  logic [9:0]           din_q;
  logic                 en_q;
  logic [AW-1:0]        cnt, cnt_nxt;
  logic                 wr_bank, wr_bank_nxt;
  logic                 rd_bank, rd_bank_nxt;
  logic [1:0]           full, full_nxt;
  logic [1:0][AW-1:0]   len, len_nxt;
  logic [7:0]           drop_nxt;
  logic                 wr_en_nxt;
  logic [AW:0]          wr_addr_nxt;
  logic [9:0]           wr_data_nxt;
  logic                 close;
  logic [AW-1:0]        close_len;
  logic                 drop_inc;
  logic                 is_sync;

  assign is_sync = (din_q == SYNC_A) || (din_q == SYNC_B);

  // The input word is registered once, so a word sampled on edge n is acted on
  // at edge n+1 and its RAM write is visible after that edge.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = RamWrAddr;
    wr_data_nxt = RamWrData;
    close       = 1'b0;
    close_len   = cnt;
    drop_inc    = 1'b0;
    if (!sync_success) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (en_q) begin
            state_nxt = DROP;
            if (is_sync && !full[wr_bank]) begin
              state_nxt = SYNC2;
            end else begin
              drop_inc = 1'b1;
            end
          end
        end
        SYNC2: begin
          if (en_q && is_sync) begin
            state_nxt = PAYLOAD;
            cnt_nxt   = '0;
          end else begin
            state_nxt = en_q ? DROP : IDLE;
            drop_inc  = 1'b1;
          end
        end
        PAYLOAD: begin
          if (en_q) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = {wr_bank, cnt};
            wr_data_nxt = din_q;
            cnt_nxt     = cnt + AW'(1);
            // Reaching the limit closes the frame; DROP then swallows any
            // residual words and returns to IDLE as soon as En is low.
            if (cnt == AW'(PAYLOAD_MAX - 1)) begin
              close     = 1'b1;
              close_len = cnt + AW'(1);
              state_nxt = DROP;
            end
          end else begin
            state_nxt = IDLE;
            if (cnt >= AW'(PAYLOAD_MIN)) begin
              close = 1'b1;
            end else begin
              drop_inc = 1'b1;
            end
          end
        end
        DROP: begin
          if (!en_q) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Close and ack never hit the same bank: a frame only starts when its bank
  // is empty, and the reader only releases a full bank.
  always_comb begin
    full_nxt    = full;
    len_nxt     = len;
    wr_bank_nxt = wr_bank;
    rd_bank_nxt = rd_bank;
    if (close) begin
      full_nxt[wr_bank] = 1'b1;
      len_nxt[wr_bank]  = close_len;
      wr_bank_nxt       = ~wr_bank;
    end
    if (FrameAck && full[rd_bank]) begin
      full_nxt[rd_bank] = 1'b0;
      rd_bank_nxt       = ~rd_bank;
    end
    drop_nxt = (drop_inc && (DropCnt != 8'hFF)) ? DropCnt + 8'd1 : DropCnt;
  end

  // Reader-facing outputs are registered from the next-state values so they
  // track the bank bookkeeping without an extra cycle of lag.
  always_ff @(posedge UpSig_RClk or negedge nRst) begin
    if (!nRst) begin
      state     <= IDLE;
      din_q     <= '0;
      en_q      <= 1'b0;
      cnt       <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= '0;
      len       <= '0;
      RamWrEn   <= 1'b0;
      RamWrAddr <= '0;
      RamWrData <= '0;
      FrameRdy  <= 1'b0;
      FrameBank <= 1'b0;
      FrameLen  <= '0;
      DropCnt   <= '0;
    end else begin
      state     <= state_nxt;
      din_q     <= UlDataIn;
      en_q      <= UlDataInEn;
      cnt       <= cnt_nxt;
      wr_bank   <= wr_bank_nxt;
      rd_bank   <= rd_bank_nxt;
      full      <= full_nxt;
      len       <= len_nxt;
      RamWrEn   <= wr_en_nxt;
      RamWrAddr <= wr_addr_nxt;
      RamWrData <= wr_data_nxt;
      FrameRdy  <= full_nxt[rd_bank_nxt];
      FrameBank <= rd_bank_nxt;
      FrameLen  <= len_nxt[rd_bank_nxt];
      DropCnt   <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_uplink_frame_buffer.sv
// tb_uplink_frame_buffer
//   Drives directed and randomised uplink bursts into uplink_frame_buffer and
//   compares RAM writes and reader-side outputs against a frame-level model.
module tb_uplink_frame_buffer;

  localparam int PMAX = 260;
  localparam int PMIN = 38;
  localparam logic [9:0] SA = 10'h287;
  localparam logic [9:0] SB = 10'h2B8;

  logic       UpSig_RClk = 1'b0;
  logic       nRst = 1'b0;
  logic       sync_success = 1'b1;
  logic [9:0] UlDataIn = '0;
  logic       UlDataInEn = 1'b0;
  logic       FrameAck = 1'b0;
  logic       RamWrEn;
  logic [9:0] RamWrAddr;
  logic [9:0] RamWrData;
  logic       FrameRdy;
  logic       FrameBank;
  logic [8:0] FrameLen;
  logic [7:0] DropCnt;

  uplink_frame_buffer dut (
    .UpSig_RClk  (UpSig_RClk),
    .nRst        (nRst),
    .sync_success(sync_success),
    .UlDataIn    (UlDataIn),
    .UlDataInEn  (UlDataInEn),
    .RamWrEn     (RamWrEn),
    .RamWrAddr   (RamWrAddr),
    .RamWrData   (RamWrData),
    .FrameRdy    (FrameRdy),
    .FrameBank   (FrameBank),
    .FrameLen    (FrameLen),
    .FrameAck    (FrameAck),
    .DropCnt     (DropCnt)
  );

  always #5 UpSig_RClk = ~UpSig_RClk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int first_wr_cyc = -1;
  int drive_cyc = 0;

  logic [9:0]  burst [0:511];
  logic [19:0] got_wr [$];
  logic [19:0] exp_wr [$];

  // Frame-level reference: which banks hold frames, their lengths, where the
  // next frame goes, which bank the reader sees, and the drop count.
  int m_full [2];
  int m_len  [2];
  int m_wr, m_rd, m_drop;

  always @(posedge UpSig_RClk) cyc <= cyc + 1;

  // Write monitor, sampled mid-cycle away from the active edge.
  always @(negedge UpSig_RClk) begin
    if (RamWrEn === 1'b1) begin
      got_wr.push_back({RamWrAddr, RamWrData});
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
    end
  end

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic bit isSync(input logic [9:0] w);
    return (w == SA) || (w == SB);
  endfunction

  function automatic logic [9:0] nonSync();
    logic [9:0] w;
    w = 10'($urandom);
    while (isSync(w)) w = 10'($urandom);
    return w;
  endfunction

  task automatic step();
    @(posedge UpSig_RClk);
    #2;
  endtask

  task automatic modelReset();
    m_full[0] = 0; m_full[1] = 0;
    m_len[0] = 0;  m_len[1] = 0;
    m_wr = 0; m_rd = 0; m_drop = 0;
  endtask

  task automatic modelDrop();
    if (m_drop < 255) m_drop++;
  endtask

  task automatic modelAck();
    if (m_full[m_rd] != 0) begin
      m_full[m_rd] = 0;
      m_rd ^= 1;
    end
  endtask

  // Applies the frame rules to the burst held in burst[0..n-1].
  task automatic modelBurst(input int n);
    int p, w;
    if (n == 0) return;
    if (!isSync(burst[0]) || m_full[m_wr] != 0 || n < 2 || !isSync(burst[1])) begin
      modelDrop();
      return;
    end
    p = n - 2;
    w = (p > PMAX) ? PMAX : p;
    for (int i = 0; i < w; i++) exp_wr.push_back({1'(m_wr), 9'(i), burst[2 + i]});
    if (w >= PMIN) begin
      m_full[m_wr] = 1;
      m_len[m_wr]  = w;
      m_wr ^= 1;
    end else begin
      modelDrop();
    end
  endtask

  // mode 0: payload 0,1,2,... ; mode 1: random payload with some sync values
  task automatic makeFrame(input int payload, input int mode);
    burst[0] = SA;
    burst[1] = SB;
    for (int i = 0; i < payload; i++) begin
      if (mode == 0) burst[2 + i] = 10'(i);
      else if ($urandom_range(0, 15) == 0) burst[2 + i] = SA;
      else burst[2 + i] = 10'($urandom);
    end
  endtask

  // Drives one burst then a quiet gap; optionally pulses FrameAck at gap
  // cycle ack_off and drops sync_success at word abort_at.
  task automatic applyStimulus(input int n, input int abort_at, input int ack_off);
    got_wr.delete();
    exp_wr.delete();
    first_wr_cyc = -1;
    for (int i = 0; i < n; i++) begin
      step();
      UlDataIn   = burst[i];
      UlDataInEn = 1'b1;
      if (i == 2) drive_cyc = cyc;
      if (i == abort_at) sync_success = 1'b0;
    end
    step();
    UlDataInEn = 1'b0;
    UlDataIn   = 10'($urandom);
    FrameAck   = (ack_off == 0);
    for (int k = 1; k < 8; k++) begin
      step();
      FrameAck = (k == ack_off);
    end
    step();
    FrameAck = 1'b0;
    sync_success = 1'b1;
    step();
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_rdy"}, int'(FrameRdy), m_full[m_rd]);
    checkOutput({tag, "_bank"}, int'(FrameBank), m_rd);
    checkOutput({tag, "_len"}, int'(FrameLen), m_len[m_rd]);
    checkOutput({tag, "_drop"}, int'(DropCnt), m_drop);
  endtask

  task automatic checkBurst(input string tag);
    int m;
    checkOutput({tag, "_nwr"}, got_wr.size(), exp_wr.size());
    m = (got_wr.size() < exp_wr.size()) ? got_wr.size() : exp_wr.size();
    for (int i = 0; i < m; i++) checkOutput({tag, "_wr"}, int'(got_wr[i]), int'(exp_wr[i]));
    checkState(tag);
  endtask

  task automatic doAck(input string tag);
    step();
    FrameAck = 1'b1;
    step();
    FrameAck = 1'b0;
    modelAck();
    checkState(tag);
  endtask

  initial begin
    int n, t, d0, nw;
    modelReset();

    // reset values
    step(); step();
    checkOutput("rst_wren", int'(RamWrEn), 0);
    checkOutput("rst_addr", int'(RamWrAddr), 0);
    checkState("rst");
    nRst = 1'b1;
    step(); step();

    // T1: full-length frame into bank 0, with write latency check
    makeFrame(260, 0);
    applyStimulus(262, -1, -1);
    modelBurst(262);
    checkBurst("t1");
    checkOutput("t1_latency", first_wr_cyc - drive_cyc, 2);
    checkOutput("t1_len_abs", int'(FrameLen), 260);

    // T2: second frame fills bank 1, third is dropped, then acks
    makeFrame(100, 1);
    applyStimulus(102, -1, -1);
    modelBurst(102);
    checkBurst("t2_b1");
    makeFrame(80, 1);
    applyStimulus(82, -1, -1);
    modelBurst(82);
    checkBurst("t2_full");
    checkOutput("t2_drop_abs", int'(DropCnt), 1);
    doAck("t2_ack1");
    checkOutput("t2_bank_abs", int'(FrameBank), 1);
    doAck("t2_ack2");
    doAck("t2_ack_empty");

    // T3: valid 50-word frame, then a 10-word short frame
    makeFrame(50, 1);
    applyStimulus(52, -1, -1);
    modelBurst(52);
    checkBurst("t3_50");
    doAck("t3_ack");
    makeFrame(10, 1);
    applyStimulus(12, -1, -1);
    modelBurst(12);
    checkBurst("t3_short");

    // boundaries: exactly PMIN, PMIN-1 and an overflowing burst
    makeFrame(PMIN, 1);
    applyStimulus(PMIN + 2, -1, -1);
    modelBurst(PMIN + 2);
    checkBurst("min");
    doAck("min_ack");
    makeFrame(PMIN - 1, 1);
    applyStimulus(PMIN + 1, -1, -1);
    modelBurst(PMIN + 1);
    checkBurst("min_m1");
    makeFrame(300, 1);
    applyStimulus(302, -1, -1);
    modelBurst(302);
    checkBurst("ovf");
    doAck("ovf_ack");

    // T4: bad first word, then bad second word
    burst[0] = 10'h155;
    for (int i = 1; i < 20; i++) burst[i] = 10'($urandom);
    applyStimulus(20, -1, -1);
    modelBurst(20);
    checkBurst("t4_bad1");
    burst[0] = SA;
    burst[1] = 10'h100;
    applyStimulus(5, -1, -1);
    modelBurst(5);
    checkBurst("t4_bad2");
    burst[0] = SB;
    applyStimulus(1, -1, -1);
    modelBurst(1);
    checkBurst("t4_lone");

    // T5: link sync lost at payload word 100
    doAck("t5_pre");
    d0 = m_drop;
    makeFrame(200, 1);
    applyStimulus(202, 102, -1);
    nw = got_wr.size();
    checkOutput("t5_nwr_range", int'(nw >= 95 && nw <= 100), 1);
    for (int i = 0; i < nw && i < 100; i++)
      checkOutput("t5_wr", int'(got_wr[i]), int'({1'(m_wr), 9'(i), burst[2 + i]}));
    checkOutput("t5_drop_abs", int'(DropCnt), d0);
    checkState("t5");
    makeFrame(45, 1);
    applyStimulus(47, -1, -1);
    modelBurst(47);
    checkBurst("t5_after");
    doAck("t5_ack");

    // T6: ack the older bank around the cycle the newer frame closes
    for (int k = 0; k < 4; k++) begin
      d0 = m_drop;
      makeFrame(50, 1);
      applyStimulus(52, -1, -1);
      modelBurst(52);
      checkBurst("t6_a");
      makeFrame(60 + k, 1);
      applyStimulus(62 + k, -1, k);
      modelBurst(62 + k);
      modelAck();
      checkBurst("t6_b");
      checkOutput("t6_rdy_abs", int'(FrameRdy), 1);
      checkOutput("t6_drop_abs", int'(DropCnt), d0);
      doAck("t6_clr");
    end

    // randomised frames with random acks
    for (int r = 0; r < 24; r++) begin
      t = $urandom_range(0, 5);
      case (t)
        0: begin n = $urandom_range(PMIN, PMAX - 1); makeFrame(n, 1); n += 2; end
        1: begin n = $urandom_range(0, PMIN - 1);    makeFrame(n, 1); n += 2; end
        2: begin n = $urandom_range(PMAX, PMAX + 20); makeFrame(n, 1); n += 2; end
        3: begin
          n = $urandom_range(1, 20);
          burst[0] = nonSync();
          for (int i = 1; i < n; i++) burst[i] = 10'($urandom);
        end
        4: begin
          n = $urandom_range(2, 20);
          makeFrame(n, 1);
          burst[1] = nonSync();
        end
        default: begin n = 1; burst[0] = SA; end
      endcase
      applyStimulus(n, -1, -1);
      modelBurst(n);
      checkBurst("rand");
      if ($urandom_range(0, 1) == 1) doAck("rand_ack");
    end

    // DropCnt saturation
    for (int r = 0; r < 260; r++) begin
      burst[0] = nonSync();
      applyStimulus(1, -1, -1);
      modelBurst(1);
    end
    checkState("sat");
    checkOutput("sat_abs", int'(DropCnt), 255);

    // asynchronous reset in the middle of a frame, with a bank already full
    doAck("rs_pre1");
    doAck("rs_pre2");
    makeFrame(40, 1);
    applyStimulus(42, -1, -1);
    modelBurst(42);
    checkBurst("rs_fill");
    makeFrame(60, 1);
    for (int i = 0; i < 12; i++) begin
      step();
      UlDataIn   = burst[i];
      UlDataInEn = 1'b1;
    end
    #1 nRst = 1'b0;
    #1;
    modelReset();
    checkOutput("rs_wren", int'(RamWrEn), 0);
    checkState("rs_async");
    step();
    UlDataInEn = 1'b0;
    step();
    nRst = 1'b1;
    step(); step();
    makeFrame(70, 1);
    applyStimulus(72, -1, -1);
    modelBurst(72);
    checkBurst("rs_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
